// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for the multi-port register file.
//   RF_DATA_W / RF_ADDR_W / RF_CNT_W : default register width, index width,
//                                       in-flight counter width
//   rf_depth()  : number of registers for a given index width
//   port_lo()   : low bit of port slice within a packed per-port bus
package rf_pkg;

    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_CNT_W  = 2;

    function automatic int unsigned rf_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

    function automatic int unsigned port_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register in-flight write counters for the register file.
//   clk, reset      : clock, asynchronous active-high reset
//   rd_addr         : packed read indices, NUM_RD x ADDR_W
//   rd_busy         : per read port, outstanding write to that register
//   wr_en, wr_addr  : write-back strobe and index (decrements counter)
//   iss_valid/addr  : issuing instruction destination (increments counter)
//   iss_ready       : 0 when the destination counter is saturated
//   err             : sticky, write-back seen with counter already 0
// Optional feature macro: RF_BYPASS_EN (busy cleared during the draining write-back).
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = RF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic                     err
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);

    logic [CNT_W-1:0] cnt [DEPTH];
    logic             issue_acc;
    logic             wb;
    logic [DEPTH-1:0] inc_hot;
    logic [DEPTH-1:0] dec_hot;

    // A same-cycle write-back to a saturated register frees a slot, so issue may proceed.
    always_comb begin
        iss_ready = 1'b1;
        if (iss_addr != '0 && cnt[iss_addr] == '1 && !(wr_en && wr_addr == iss_addr))
            iss_ready = 1'b0;
    end

    assign issue_acc = iss_valid && iss_ready && (iss_addr != '0);
    assign wb        = wr_en && (wr_addr != '0);

    always_comb begin
        inc_hot = '0;
        dec_hot = '0;
        if (issue_acc) inc_hot[iss_addr] = 1'b1;
        if (wb)        dec_hot[wr_addr]  = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) cnt[r] <= '0;
            err <= 1'b0;
        end else begin
            for (int unsigned r = 1; r < DEPTH; r++) begin
                if (inc_hot[r] && !dec_hot[r])
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec_hot[r] && !inc_hot[r] && cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
            // Issue and write-back to the same idle register cancel out without error.
            if (wb && cnt[wr_addr] == '0 && !(issue_acc && iss_addr == wr_addr))
                err <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];
`ifdef RF_BYPASS_EN
        logic drain;
        // Final write-back is forwarded this cycle, so the reader need not stall.
        assign drain = wb && (wr_addr == a) && (cnt[a] == CNT_W'(1))
                       && !(issue_acc && iss_addr == a);
        assign rd_busy[i] = (cnt[a] != '0) && !drain;
`else
        assign rd_busy[i] = (cnt[a] != '0);
`endif
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with pending-write scoreboard.
//   clk, reset : clock, asynchronous active-high reset (clears data, counters, err)
//   rd_addr    : NUM_RD packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    : NUM_RD packed combinational read data
//   rd_busy    : per read port, in-flight write outstanding
//   wr_en/wr_addr/wr_data : write-back port
//   iss_valid/iss_addr/iss_ready : issue tracking and stall
//   err        : sticky unexpected write-back flag
// Optional feature macro: RF_BYPASS_EN (write-first forwarding onto rd_data).
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W = RF_DATA_W,
    parameter int unsigned ADDR_W = RF_ADDR_W,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned CNT_W  = RF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ready,
    output logic                     err
);

    localparam int unsigned DEPTH = rf_depth(ADDR_W);

    logic [DATA_W-1:0] regs [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[port_lo(i, ADDR_W) +: ADDR_W];
        always_comb begin
            rd_data[port_lo(i, DATA_W) +: DATA_W] = '0;
            if (a != '0) begin
`ifdef RF_BYPASS_EN
                if (wr_en && wr_addr == a)
                    rd_data[port_lo(i, DATA_W) +: DATA_W] = wr_data;
                else
                    rd_data[port_lo(i, DATA_W) +: DATA_W] = regs[a];
`else
                rd_data[port_lo(i, DATA_W) +: DATA_W] = regs[a];
`endif
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD),
        .CNT_W  (CNT_W)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .err       (err)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized + directed bench for regfile_mp (default parameters,
// two read ports). Expected responses come from an array-based model and are
// queued per cycle; a negedge monitor pops and compares.
module tb_regfile_mp;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic        iss_ready;
    logic        err;

    regfile_mp #(
        .DATA_W (32),
        .ADDR_W (5),
        .NUM_RD (2),
        .CNT_W  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .iss_ready (iss_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic        rdy;
        logic        err;
    } exp_t;

    exp_t        expq[$];
    int          checks = 0;
    int          errors = 0;

    logic [31:0] reg_m [32];
    int          cnt_m [32];
    bit          err_m;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("rd_data0",  rd_data[31:0],  e.d0);
            chk("rd_data1",  rd_data[63:32], e.d1);
            chk("rd_busy",   {30'd0, rd_busy}, {30'd0, e.busy});
            chk("iss_ready", {31'd0, iss_ready}, {31'd0, e.rdy});
            chk("err",       {31'd0, err}, {31'd0, e.err});
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'd0;
`ifdef RF_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return reg_m[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a, input logic we, input logic [4:0] wa,
                                        input bit acc, input logic [4:0] ia);
        logic b;
        b = (cnt_m[a] != 0);
`ifdef RF_BYPASS_EN
        if (we && a != 0 && wa == a && cnt_m[a] == 1 && !(acc && ia == a)) b = 1'b0;
`endif
        return b;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < 32; r++) begin
            reg_m[r] = 32'd0;
            cnt_m[r] = 0;
        end
        err_m = 1'b0;
    endfunction

    // Called at a rising edge; drives one cycle of stimulus and advances the model at the next edge.
    task automatic cycle(input logic [4:0] a0, input logic [4:0] a1, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [4:0] ia);
        exp_t e;
        bit   rdy, acc;
        #1;
        rd_addr   = {a1, a0};
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        iss_valid = iv;
        iss_addr  = ia;
        rdy = (ia == 0) || (cnt_m[ia] < MAXC) || (we && wa == ia);
        acc = iv && rdy && (ia != 0);
        e.d0      = model_read(a0, we, wa, wd);
        e.d1      = model_read(a1, we, wa, wd);
        e.busy[0] = model_busy(a0, we, wa, acc, ia);
        e.busy[1] = model_busy(a1, we, wa, acc, ia);
        e.rdy     = rdy;
        e.err     = err_m;
        expq.push_back(e);
        @(posedge clk);
        if (we && wa != 0) reg_m[wa] = wd;
        if (acc) cnt_m[ia] = cnt_m[ia] + 1;
        if (we && wa != 0) begin
            if (cnt_m[wa] > 0) cnt_m[wa] = cnt_m[wa] - 1;
            else err_m = 1'b1;
        end
    endtask

    // Reset asserted shortly after an edge; outputs must clear before the next edge.
    task automatic do_reset(input logic [4:0] a0, input logic [4:0] a1);
        exp_t e;
        #1;
        reset     = 1'b1;
        rd_addr   = {a1, a0};
        wr_en     = 1'b0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        model_clear();
        e.d0 = 32'd0; e.d1 = 32'd0; e.busy = 2'b00; e.rdy = 1'b1; e.err = 1'b0;
        expq.push_back(e);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] ra, rb, wa, ia;
        model_clear();
        @(posedge clk);
        do_reset(5'd3, 5'd4);

        // All indices read zero and idle after reset.
        for (int i = 0; i < 32; i++)
            cycle(5'(i), 5'(31 - i), 1'b0, 5'd0, 32'd0, 1'b0, 5'(i));

        // Write r5, read back; r0 ignores writes.
        cycle(5'd5, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
        cycle(5'd5, 5'd0, 1'b1, 5'd0, 32'h00000001, 1'b0, 5'd0);
        cycle(5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Same-cycle write/read of r7.
        cycle(5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0);
        cycle(5'd7, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // r3 saturation, rejected issue, issue+write-back, then drain.
        for (int i = 0; i < 3; i++)
            cycle(5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cycle(5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
        cycle(5'd3, 5'd0, 1'b1, 5'd3, 32'hA5A5A5A5, 1'b1, 5'd3);
        cycle(5'd3, 5'd3, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3);
        for (int i = 0; i < 3; i++)
            cycle(5'd3, 5'd0, 1'b1, 5'd3, 32'(i + 100), 1'b0, 5'd3);
        cycle(5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd3);

        // Unexpected write-back sets sticky err; reset clears it.
        cycle(5'd9, 5'd0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0);
        cycle(5'd9, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        cycle(5'd9, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
        do_reset(5'd9, 5'd5);
        cycle(5'd9, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);

        // Reset while an issue to r4 is still pending.
        cycle(5'd4, 5'd0, 1'b1, 5'd4, 32'h44444444, 1'b1, 5'd4);
        cycle(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
        do_reset(5'd4, 5'd0);
        cycle(5'd4, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd4);

        // Randomized traffic over a small register window to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            ra = 5'($urandom_range(0, 7));
            rb = 5'($urandom_range(0, 7));
            wa = 5'($urandom_range(0, 7));
            ia = 5'($urandom_range(0, 7));
            if (n == 750) do_reset(ra, rb);
            cycle(ra, rb, 1'($urandom_range(0, 1)), wa, $urandom,
                  1'($urandom_range(0, 1)), ia);
        end

        do_reset(5'd1, 5'd2);
        cycle(5'd1, 5'd2, 1'b0, 5'd0, 32'd0, 1'b0, 5'd1);

        for (int w = 0; w < 10 && expq.size() > 0; w++) @(posedge clk);
        if (expq.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d exp 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
